// File: rtl/ram_sched_pkg.sv
// Shared types for the RAM port-B scheduler: FSM states, read owner tags
// and the default RAM read latency.
package ram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } sched_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_AUX
    } owner_t;

    localparam int DEFAULT_READ_LATENCY = 2;

endpackage

// File: rtl/read_tag_pipe.sv
// Shift register of read-owner tags, one stage per cycle of RAM read latency,
// so returning data can be routed to whoever issued the read.
module read_tag_pipe
    import ram_sched_pkg::*;
#(
    parameter int DEPTH = DEFAULT_READ_LATENCY
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_t tag_in,
    output owner_t tag_out,
    output logic   aux_pending
);

    owner_t stage_q [DEPTH];
    owner_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

    // Includes the output stage, so a burst is not finished until its last word has been delivered.
    always_comb begin
        aux_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i] == OWN_AUX) begin
                aux_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_b_scheduler.sv
// Shares RAM port B between the VGA scan-out (absolute priority) and an
// auxiliary host doing burst reads and single-word writes in free cycles.
module ram_port_b_scheduler
    import ram_sched_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int LEN_WIDTH    = 13
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic                  vga_fetch,
    input  logic [ADDR_WIDTH-1:0] vga_address,
    output logic [DATA_WIDTH-1:0] vga_word,
    input  logic                  aux_start,
    input  logic [ADDR_WIDTH-1:0] aux_base,
    input  logic [LEN_WIDTH-1:0]  aux_len,
    output logic                  aux_busy,
    output logic                  aux_rvalid,
    output logic [DATA_WIDTH-1:0] aux_rdata,
    output logic                  aux_done,
    input  logic                  aux_wr_req,
    input  logic [ADDR_WIDTH-1:0] aux_wr_address,
    input  logic [DATA_WIDTH-1:0] aux_wr_data,
    output logic                  aux_wr_ack,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    sched_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  len0_done_q, len0_done_d;
    logic                  burst_done;
    owner_t                issue_tag;
    owner_t                out_tag;
    logic                  aux_pending;

    read_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_tag_pipe (
        .clk        (CLK_50),
        .reset      (reset),
        .tag_in     (issue_tag),
        .tag_out    (out_tag),
        .aux_pending(aux_pending)
    );

    // Aux accesses are suppressed while reset is high so an abort never leaks a stray write.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        len0_done_d   = 1'b0;
        burst_done    = 1'b0;
        issue_tag     = vga_fetch ? OWN_VGA : OWN_NONE;
        ram_address_b = vga_address;
        ram_data_b    = '0;
        ram_wren_b    = 1'b0;
        aux_wr_ack    = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (aux_start) begin
                        if (aux_len != '0) begin
                            addr_d      = aux_base;
                            remaining_d = aux_len;
                            state_d     = BURST;
                        end else begin
                            len0_done_d = 1'b1;
                        end
                    end else if (aux_wr_req && !vga_fetch) begin
                        ram_address_b = aux_wr_address;
                        ram_data_b    = aux_wr_data;
                        ram_wren_b    = 1'b1;
                        aux_wr_ack    = 1'b1;
                    end
                end
                BURST: begin
                    if (!vga_fetch) begin
                        ram_address_b = addr_q;
                        issue_tag     = OWN_AUX;
                        addr_d        = addr_q + ADDR_WIDTH'(1);
                        remaining_d   = remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!aux_pending) begin
                        burst_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The hold register keeps the last display word stable between fetches.
    always_comb begin
        hold_d     = hold_q;
        vga_word   = hold_q;
        aux_rvalid = 1'b0;
        aux_rdata  = '0;
        if (out_tag == OWN_VGA) begin
            hold_d   = ram_q_b;
            vga_word = ram_q_b;
        end
        if (out_tag == OWN_AUX) begin
            aux_rvalid = 1'b1;
            aux_rdata  = ram_q_b;
        end
    end

    assign aux_done = burst_done | len0_done_q;
    assign aux_busy = (state_q != IDLE);

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            len0_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            len0_done_q <= len0_done_d;
        end
    end

endmodule

// File: tb/tb_ram_port_b_scheduler.sv
// Randomised self-checking bench for ram_port_b_scheduler with a RAM model
// and a transaction-level reference of expected returns and handshakes.
module tb_ram_port_b_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_fetch;
    logic [11:0] vga_address;
    logic [15:0] vga_word;
    logic        aux_start;
    logic [11:0] aux_base;
    logic [12:0] aux_len;
    logic        aux_busy;
    logic        aux_rvalid;
    logic [15:0] aux_rdata;
    logic        aux_done;
    logic        aux_wr_req;
    logic [11:0] aux_wr_address;
    logic [15:0] aux_wr_data;
    logic        aux_wr_ack;
    logic [11:0] ram_address_b;
    logic [15:0] ram_data_b;
    logic        ram_wren_b;
    logic [15:0] ram_q_b;

    always #5 clk = ~clk;

    ram_port_b_scheduler dut (
        .CLK_50        (clk),
        .reset         (reset),
        .vga_fetch     (vga_fetch),
        .vga_address   (vga_address),
        .vga_word      (vga_word),
        .aux_start     (aux_start),
        .aux_base      (aux_base),
        .aux_len       (aux_len),
        .aux_busy      (aux_busy),
        .aux_rvalid    (aux_rvalid),
        .aux_rdata     (aux_rdata),
        .aux_done      (aux_done),
        .aux_wr_req    (aux_wr_req),
        .aux_wr_address(aux_wr_address),
        .aux_wr_data   (aux_wr_data),
        .aux_wr_ack    (aux_wr_ack),
        .ram_address_b (ram_address_b),
        .ram_data_b    (ram_data_b),
        .ram_wren_b    (ram_wren_b),
        .ram_q_b       (ram_q_b)
    );

    // Two-cycle registered-read RAM standing in for the dual-port IP.
    logic [15:0] ram_mem [4096];
    logic [15:0] ram_p1;
    always @(posedge clk) begin
        if (ram_wren_b) ram_mem[ram_address_b] <= ram_data_b;
        ram_p1  <= ram_mem[ram_address_b];
        ram_q_b <= ram_p1;
    end

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } ret_t;

    logic [15:0] ref_mem [4096];
    ret_t        vga_q[$];
    ret_t        aux_q[$];
    logic [15:0] m_hold;
    bit          m_busy;
    int          m_left;
    logic [11:0] m_addr;
    int          done_at;
    int          rv_seen;

    int          cyc;
    int          total;
    int          bad;
    bit          rst_next;
    bit          wr_pending;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    int          dut_rv_cnt;
    logic [15:0] last_rdata;
    int          last_done_cyc;
    int          last_ack_cyc;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        vga_q.delete();
        aux_q.delete();
        m_hold     = '0;
        m_busy     = 1'b0;
        m_left     = 0;
        m_addr     = '0;
        done_at    = -1;
        wr_pending = 1'b0;
    endtask

    // Expected behaviour per cycle: reads to free slots in order, data back two cycles later.
    task automatic checkCycle();
        bit          exp_rv;
        bit          exp_wr;
        logic [15:0] exp_rd;
        if (vga_q.size() > 0 && vga_q[0].cyc + 2 == cyc) begin
            m_hold = vga_q[0].data;
            void'(vga_q.pop_front());
        end
        exp_rv = (aux_q.size() > 0 && aux_q[0].cyc == cyc);
        exp_rd = exp_rv ? aux_q[0].data : 16'h0000;
        if (exp_rv) begin
            void'(aux_q.pop_front());
            rv_seen++;
        end
        exp_wr = !m_busy && !aux_start && aux_wr_req && !vga_fetch;

        checkOutput("vga_word", 32'(vga_word), 32'(m_hold));
        checkOutput("aux_rvalid", 32'(aux_rvalid), 32'(exp_rv));
        checkOutput("aux_rdata", 32'(aux_rdata), 32'(exp_rd));
        checkOutput("aux_done", 32'(aux_done), 32'(done_at == cyc));
        checkOutput("aux_busy", 32'(aux_busy), 32'(m_busy));
        checkOutput("aux_wr_ack", 32'(aux_wr_ack), 32'(exp_wr));
        checkOutput("ram_wren_b", 32'(ram_wren_b), 32'(exp_wr));
        if (vga_fetch) checkOutput("vga_addr_out", 32'(ram_address_b), 32'(vga_address));
        if (exp_wr) begin
            checkOutput("wr_addr_out", 32'(ram_address_b), 32'(aux_wr_address));
            checkOutput("wr_data_out", 32'(ram_data_b), 32'(aux_wr_data));
        end

        if (aux_rvalid) begin
            dut_rv_cnt++;
            last_rdata = aux_rdata;
        end
        if (aux_done) last_done_cyc = cyc;
        if (aux_wr_ack) last_ack_cyc = cyc;

        if (vga_fetch) begin
            vga_q.push_back('{cyc: cyc, data: ref_mem[vga_address]});
        end else if (m_busy && m_left > 0) begin
            aux_q.push_back('{cyc: cyc + 2, data: ref_mem[m_addr]});
            m_addr = m_addr + 12'd1;
            m_left--;
            if (m_left == 0) done_at = cyc + 3;
        end
        if (exp_wr) begin
            ref_mem[aux_wr_address] = aux_wr_data;
            wr_pending = 1'b0;
        end
        if (m_busy && done_at == cyc) begin
            m_busy = 1'b0;
        end else if (!m_busy && aux_start) begin
            if (aux_len == 13'd0) begin
                done_at = cyc + 1;
            end else begin
                m_busy  = 1'b1;
                m_left  = int'(aux_len);
                m_addr  = aux_base;
                rv_seen = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit f, input logic [11:0] va, input bit st,
                                 input logic [11:0] b, input logic [12:0] l);
        @(posedge clk);
        #1;
        cyc++;
        reset          = rst_next;
        vga_fetch      = f;
        vga_address    = va;
        aux_start      = st;
        aux_base       = b;
        aux_len        = l;
        aux_wr_req     = wr_pending;
        aux_wr_address = wr_addr;
        aux_wr_data    = wr_data;
        @(negedge clk);
        if (reset) modelReset();
        else checkCycle();
    endtask

    task automatic runCycles(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            applyStimulus(toggle && (i % 2 == 0), 12'($urandom_range(0, 4095)), 1'b0, 12'h000, 13'd0);
        end
    endtask

    task automatic runBurst(input logic [11:0] b, input logic [12:0] l, input bit toggle);
        dut_rv_cnt = 0;
        applyStimulus(1'b0, 12'h000, 1'b1, b, l);
        runCycles(20, toggle);
        checkOutput("rv_count", 32'(dut_rv_cnt), 32'(l));
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        wr_addr = '0;
        wr_data = '0;
        last_done_cyc = -1;
        last_ack_cyc = -1;
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 16'($urandom());
            ref_mem[i] = ram_mem[i];
        end
        reset = 1'b1;
        vga_fetch = 1'b0;
        vga_address = '0;
        aux_start = 1'b0;
        aux_base = '0;
        aux_len = '0;
        aux_wr_req = 1'b0;
        aux_wr_address = '0;
        aux_wr_data = '0;
        modelReset();

        rst_next = 1'b1;
        runCycles(3, 1'b0);
        rst_next = 1'b0;
        runCycles(2, 1'b0);

        $display("[TB] display-only fetches");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 12'(i), 1'b0, 12'h000, 13'd0);
        runCycles(3, 1'b0);

        $display("[TB] bursts: plain, interleaved, wrap-around");
        runBurst(12'h100, 13'd4, 1'b0);
        checkOutput("burst_done_after_last", 32'(last_done_cyc), 32'(done_at));
        runBurst(12'h100, 13'd4, 1'b1);
        runBurst(12'hFFE, 13'd4, 1'b0);

        $display("[TB] write blocked by display, then issued");
        wr_addr = 12'h020;
        wr_data = 16'hBEEF;
        wr_pending = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 12'h000, 13'd0);
        runCycles(2, 1'b0);
        runBurst(12'h020, 13'd1, 1'b0);
        checkOutput("beef_read", 32'(last_rdata), 32'h0000BEEF);

        $display("[TB] write requested during a burst");
        applyStimulus(1'b0, 12'h000, 1'b1, 12'h200, 13'd6);
        wr_addr = 12'h030;
        wr_data = 16'h1234;
        wr_pending = 1'b1;
        runCycles(20, 1'b0);
        checkOutput("ack_after_done", 32'(last_ack_cyc > last_done_cyc), 32'd1);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 12'h000, 1'b1, 12'h300, 13'd8);
        for (int i = 0; i < 40 && rv_seen < 3; i++) runCycles(1, 1'b0);
        checkOutput("rv3_reached", 32'(rv_seen), 32'd3);
        rst_next = 1'b1;
        runCycles(1, 1'b0);
        rst_next = 1'b0;
        last_done_cyc = -1;
        runCycles(12, 1'b0);
        checkOutput("no_done_after_reset", 32'(last_done_cyc), 32'hFFFFFFFF);

        $display("[TB] zero-length burst");
        runBurst(12'h055, 13'd0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            if (!wr_pending && $urandom_range(0, 9) == 0) begin
                wr_addr = 12'($urandom_range(0, 4095));
                wr_data = 16'($urandom());
                wr_pending = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                          ($urandom_range(0, 14) == 0), 12'($urandom_range(0, 4095)),
                          13'($urandom_range(0, 12)));
        end
        wr_pending = 1'b0;
        runCycles(30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_b_scheduler.md
Name: ram_port_b_scheduler

Overview:
- Shares RAM port B, currently owned by the VGA scan-out, between the display reader and an auxiliary host requester (memory dump / debug loader).
- VGA always has absolute priority. The auxiliary side gets only cycles in which the display is not fetching.
- Supports auxiliary burst reads with a streamed return path and single-word writes.
- Sits between the word-address logic and port B of the dual-port ram in top, in the CLK_50 domain.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 12, port-B address width (RAM holds 2**ADDR_WIDTH words).
- READ_LATENCY, 2, cycles from address on ram_address_b to valid ram_q_b (fixed by the ram IP).
- LEN_WIDTH, 13, width of the burst length field (allows a full-memory dump of 4096 words).

Ports:
- CLK_50  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- vga_fetch  in  1  display needs port B this cycle.
- vga_address  in  ADDR_WIDTH  display word address.
- vga_word  out  DATA_WIDTH  display read data, READ_LATENCY after the request.
- aux_start  in  1  pulse: begin burst read.
- aux_base  in  ADDR_WIDTH  burst start address, sampled on aux_start.
- aux_len  in  LEN_WIDTH  burst word count, sampled on aux_start.
- aux_busy  out  1  burst in progress.
- aux_rvalid  out  1  aux_rdata valid this cycle.
- aux_rdata  out  DATA_WIDTH  burst return data, in address order.
- aux_done  out  1  one-cycle pulse after the last aux_rvalid.
- aux_wr_req  in  1  level: write request, held until acknowledged.
- aux_wr_address  in  ADDR_WIDTH  write address.
- aux_wr_data  in  DATA_WIDTH  write data.
- aux_wr_ack  out  1  one-cycle pulse in the cycle the write is issued.
- ram_address_b  out  ADDR_WIDTH  to ram.
- ram_data_b  out  DATA_WIDTH  to ram.
- ram_wren_b  out  1  to ram.
- ram_q_b  in  DATA_WIDTH  from ram.

Behaviour:
- Slot arbitration (combinational, per cycle):
  - vga_fetch=1: ram_address_b=vga_address, ram_wren_b=0. The auxiliary side is stalled.
  - Otherwise the slot is free for aux. When no aux access is issued, ram_address_b holds vga_address and ram_wren_b=0.
- Return routing:
  - A READ_LATENCY-deep tag shift register records the owner of each issued read: NONE, VGA or AUX.
  - At the output stage, tag VGA: vga_word=ram_q_b, and the value is captured into a hold register.
  - Any other tag: vga_word=hold register.
  - Tag AUX: aux_rvalid=1, aux_rdata=ram_q_b.
- FSM states and transitions:
  - IDLE.
    - aux_start with aux_len>0: latch base/len into addr/remaining counters, go to BURST.
    - aux_start with aux_len=0: pulse aux_done next cycle, stay IDLE.
    - aux_wr_req and free slot: ram_wren_b=1 with aux_wr_address/aux_wr_data, aux_wr_ack=1.
    - aux_start and aux_wr_req in the same cycle: the write waits; start takes priority.
  - BURST.
    - On each free slot, issue a read at addr: tag AUX, addr+1 (wraps modulo 2**ADDR_WIDTH), remaining-1.
    - After the last issue, go to DRAIN.
    - Writes are not serviced; aux_wr_req stays pending.
  - DRAIN. When no AUX tag remains in the pipeline, pulse aux_done for one cycle and return to IDLE.
- aux_busy=1 in BURST and DRAIN.
- aux_start while busy is ignored.
- Reset values:
  - State IDLE, tags NONE, hold register 0.
  - aux_busy=0, aux_rvalid=0, aux_done=0, aux_wr_ack=0, ram_wren_b=0, aux_rdata=0, vga_word=0.
- Reset mid-burst aborts immediately. In-flight data is discarded and no aux_done pulse is issued.
- Invariants:
  - VGA latency is exactly READ_LATENCY, independent of aux activity.
  - aux_rvalid count equals the latched len.

Decomposition:
- Package ram_sched_pkg holds:
  - typedef enum sched_state_t {IDLE, BURST, DRAIN};
  - typedef enum owner_t {OWN_NONE, OWN_VGA, OWN_AUX};
  - constant DEFAULT_READ_LATENCY.
- One sub-module: read_tag_pipe (parameterised shift register of owner_t, depth READ_LATENCY).

Test Plan:
- vga_fetch=1 constantly, addresses 0..15, aux idle:
  - vga_word follows the RAM contents exactly 2 cycles later.
  - ram_wren_b never asserts.
- vga_fetch=0, aux_start with base=0x100, len=4:
  - 4 aux_rvalid pulses with mem[0x100..0x103].
  - aux_done is one cycle after the last pulse.
  - aux_busy spans the burst.
- Same burst with vga_fetch toggling every other cycle:
  - Aux reads occur only on free cycles; data stays in order; total 4 pulses.
  - vga_word stays correct and holds between fetches.
- Wrap-around, base=0xFFE, len=4: returns mem[0xFFE], mem[0xFFF], mem[0x000], mem[0x001].
- aux_wr_req (0x020 <= 0xBEEF):
  - Under vga_fetch=1 for 5 cycles, no ack.
  - On the first free cycle, ack pulses and a later burst read of 0x020 returns 0xBEEF.
  - A write requested during a burst is acked only after aux_done.
- Edge cases:
  - Reset asserted mid-burst (len=8, after 3 returns): all outputs return to reset values next cycle, and no aux_done is issued.
  - aux_len=0: a single aux_done pulse with no aux_rvalid.
